// File: rtl/regfile_wb_ctrl_if.sv
// Issue, write-back and register-file port bundle for the write-back controller.
// The pipeline side drives the master view and the controller uses the slave view.
interface regfile_wb_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  logic              issue_valid;
  logic [4:0]        issue_rs1;
  logic [4:0]        issue_rs2;
  logic [4:0]        issue_rd;
  logic              issue_stall;

  logic              alu_wb_valid;
  logic [4:0]        alu_wb_rd;
  logic [XLEN-1:0]   alu_wb_data;
  logic              alu_wb_ready;

  logic              lsu_wb_valid;
  logic [4:0]        lsu_wb_rd;
  logic [XLEN-1:0]   lsu_wb_data;
  logic              lsu_wb_ready;

  logic [4:0]        rf_rd_address;
  logic [XLEN-1:0]   rf_rd_value;
  logic [NREGS-1:0]  busy;
  logic              sb_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    input  issue_stall, alu_wb_ready, lsu_wb_ready,
    input  rf_rd_address, rf_rd_value, busy, sb_err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    output issue_stall, alu_wb_ready, lsu_wb_ready,
    output rf_rd_address, rf_rd_value, busy, sb_err
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller for the RV32I register file: pending-write scoreboard,
// RAW/WAW issue stall and round-robin arbitration of the single write port.
module regfile_wb_ctrl #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic                clk,
  input logic                reset,
  regfile_wb_ctrl_if.slave   bus
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  wb_src_e           rr_pri;
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_next;
  logic [4:0]        rf_addr_q;
  logic [XLEN-1:0]   rf_val_q;
  logic              sb_err_q;

  logic              alu_grant;
  logic              lsu_grant;
  logic              wb_fire;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              issue_accept;
  logic              err_set;
  logic              contention;

  // busy_q[0] is never set, so x0 operands fall straight through the OR.
  assign bus.issue_stall = bus.issue_valid &
                           (busy_q[bus.issue_rs1] | busy_q[bus.issue_rs2] | busy_q[bus.issue_rd]);
  assign issue_accept    = bus.issue_valid & ~bus.issue_stall;

  assign contention = bus.alu_wb_valid & bus.lsu_wb_valid;

  // NOTE: every output of a combinational block gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    alu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (contention) begin
      if (rr_pri == SRC_ALU) alu_grant = 1'b1;
      else                   lsu_grant = 1'b1;
    end else begin
      alu_grant = bus.alu_wb_valid;
      lsu_grant = bus.lsu_wb_valid;
    end
  end

  assign bus.alu_wb_ready = alu_grant;
  assign bus.lsu_wb_ready = lsu_grant;

  assign wb_fire = alu_grant | lsu_grant;
  assign wb_rd   = lsu_grant ? bus.lsu_wb_rd   : bus.alu_wb_rd;
  assign wb_data = lsu_grant ? bus.lsu_wb_data : bus.alu_wb_data;

  // A write-back to a register nobody is waiting on is a pipeline bug.
  assign err_set = wb_fire & (wb_rd != 5'd0) & ~busy_q[wb_rd];

  // Clear first, then set, so an issue and a write-back to the same rd leave it pending.
  always_comb begin
    busy_next = busy_q;
    if (wb_fire && wb_rd != 5'd0)
      busy_next[wb_rd] = 1'b0;
    if (issue_accept && bus.issue_rd != 5'd0)
      busy_next[bus.issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= '0;
      rf_addr_q <= 5'd0;
      rf_val_q  <= '0;
      sb_err_q  <= 1'b0;
      rr_pri    <= SRC_ALU;
    end else begin
      busy_q   <= busy_next;
      sb_err_q <= sb_err_q | err_set;
      if (contention)
        rr_pri <= (rr_pri == SRC_ALU) ? SRC_LSU : SRC_ALU;
      if (wb_fire) begin
        rf_addr_q <= wb_rd;
        rf_val_q  <= wb_data;
      end else begin
        rf_addr_q <= 5'd0;
      end
    end
  end

  assign bus.rf_rd_address = rf_addr_q;
  assign bus.rf_rd_value   = rf_val_q;
  assign bus.busy          = busy_q;
  assign bus.sb_err        = sb_err_q;

endmodule
